// File: rtl/seg_scan_controller.sv
// ---------------------------------------------------------------------------
// seg_scan_controller
//
// Drives an 8-digit, time-multiplexed seven-segment display with a 32-bit
// word shown as eight hex digits. The word is {instruction, PC}, and digit 7
// is the leftmost digit. Each digit slot has two phases:
//   * GAP: all anodes are off, which prevents ghosting.
//   * ON:  the digit is lit.
// A word written through the valid/ready port waits in a pending shadow
// register. It moves to the displayed register only on the last cycle of a
// frame, so a single frame never mixes two words.
//
// Ports
//   Clock      in   1   system clock, rising edge
//   Reset      in   1   asynchronous, active-high reset
//   Data       in   32  word to display; digit i shows Data[4i+3:4i]
//   DataValid  in   1   Data offered this cycle
//   DataReady  out  1   pending register empty (transfer on Valid & Ready)
//   BlankEn    in   1   blank leading-zero digits (digit 0 never blanked)
//   DPMask     in   8   decimal point per digit, 1 = lit
//   out7       out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp         out  1   decimal point, active-low
//   en_out     out  8   digit anodes, active-low
//   FrameDone  out  1   pulse on the last ON cycle of digit 7
// ---------------------------------------------------------------------------
module seg_scan_controller #(
   parameter int unsigned REFRESH_CYCLES = 100000,
   parameter int unsigned GAP_CYCLES     = 16,
   parameter int unsigned CNT_W          = 17
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] Data,
   input  logic        DataValid,
   output logic        DataReady,
   input  logic        BlankEn,
   input  logic [7:0]  DPMask,
   output logic [6:0]  out7,
   output logic        dp,
   output logic [7:0]  en_out,
   output logic        FrameDone
);

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned DIGIT_W = 3;

   localparam logic [0:0] PH_GAP = 1'b0;
   localparam logic [0:0] PH_ON  = 1'b1;

   localparam logic [CNT_W-1:0]   ON_LAST    = CNT_W'(REFRESH_CYCLES - 1);
   localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(7);

   localparam logic [7:0] ANODES_OFF = 8'hFF;
   localparam logic [6:0] SEGS_OFF   = 7'h7F;

   // Scan state
   logic [0:0]         phase,    phase_nx;
   logic [DIGIT_W-1:0] digit,    digit_nx;
   logic [CNT_W-1:0]   cnt,      cnt_nx;

   // Next values for the registered display outputs
   logic [7:0]         en_nx;
   logic [6:0]         seg_nx;
   logic               dp_nx;
   logic               frame_done_nx;

   // Displayed word and pending shadow word
   logic [DATA_W-1:0]  active;
   logic [DATA_W-1:0]  pending;

   // Digit decode helpers
   logic [DATA_W-1:0]  upper;
   logic [3:0]         nibble;
   logic               blank;

   // Hex to active-low {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Next-state and next-output logic.
   // The outputs are computed from the *next* state, so the registered
   // outputs line up with the state they describe. As a result, the first
   // ON cycle of a digit already shows its anode.
   always_comb begin
      phase_nx      = phase;
      digit_nx      = digit;
      cnt_nx        = cnt + CNT_W'(1);
      en_nx         = ANODES_OFF;
      seg_nx        = SEGS_OFF;
      dp_nx         = 1'b1;
      frame_done_nx = 1'b0;
      upper         = '0;
      nibble        = 4'h0;
      blank         = 1'b0;

      case (phase)
         PH_GAP: begin
            if (cnt == GAP_LAST) begin
               phase_nx = PH_ON;
               cnt_nx   = '0;
            end
         end
         PH_ON: begin
            if (cnt == ON_LAST) begin
               phase_nx = PH_GAP;
               digit_nx = digit + DIGIT_W'(1);
               cnt_nx   = '0;
            end
         end
         default: begin
            phase_nx = PH_GAP;
            digit_nx = '0;
            cnt_nx   = '0;
         end
      endcase

      // A digit is a leading zero when it and every digit to its left are zero
      upper  = active >> {digit_nx, 2'b00};
      nibble = upper[3:0];
      blank  = BlankEn && (digit_nx != '0) && (upper == '0);

      if ((phase_nx == PH_ON) && !blank) begin
         en_nx  = ~(8'b0000_0001 << digit_nx);
         seg_nx = hex7(nibble);
         dp_nx  = ~DPMask[digit_nx];
      end

      frame_done_nx = (phase_nx == PH_ON) && (digit_nx == LAST_DIGIT) &&
                      (cnt_nx == ON_LAST);
   end

   // State register and registered display outputs
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         phase     <= PH_GAP;
         digit     <= '0;
         cnt       <= '0;
         en_out    <= ANODES_OFF;
         out7      <= SEGS_OFF;
         dp        <= 1'b1;
         FrameDone <= 1'b0;
      end else begin
         phase     <= phase_nx;
         digit     <= digit_nx;
         cnt       <= cnt_nx;
         en_out    <= en_nx;
         out7      <= seg_nx;
         dp        <= dp_nx;
         FrameDone <= frame_done_nx;
      end
   end

   // Handshake and frame-boundary promotion.
   // An accept needs an empty pending register, and a promotion needs a full
   // one, so the two branches can never fire together. A word accepted in the
   // FrameDone cycle therefore waits for the next boundary.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         active    <= '0;
         pending   <= '0;
         DataReady <= 1'b1;
      end else if (DataValid && DataReady) begin
         pending   <= Data;
         DataReady <= 1'b0;
      end else if (FrameDone && !DataReady) begin
         active    <= pending;
         DataReady <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_controller
//
// Self-checking bench for seg_scan_controller with REFRESH_CYCLES = 4 and
// GAP_CYCLES = 1, which gives 5-cycle digit slots and 40-cycle frames.
// A frame-position model predicts every output on every cycle. Directed
// literal checks pin the key cycles of each scenario.
// ---------------------------------------------------------------------------
module tb_seg_scan_controller;

   localparam int unsigned REFRESH = 4;
   localparam int unsigned GAP     = 1;
   localparam int unsigned SLOT    = REFRESH + GAP;
   localparam int unsigned FRAME   = 8 * SLOT;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] Data = 32'h0;
   logic        DataValid = 1'b0;
   logic        BlankEn = 1'b0;
   logic [7:0]  DPMask = 8'h00;
   logic        DataReady;
   logic [6:0]  out7;
   logic        dp;
   logic [7:0]  en_out;
   logic        FrameDone;

   seg_scan_controller #(
      .REFRESH_CYCLES(REFRESH),
      .GAP_CYCLES    (GAP),
      .CNT_W         (17)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Data     (Data),
      .DataValid(DataValid),
      .DataReady(DataReady),
      .BlankEn  (BlankEn),
      .DPMask   (DPMask),
      .out7     (out7),
      .dp       (dp),
      .en_out   (en_out),
      .FrameDone(FrameDone)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit cmp_en   = 1'b0;

   // Model state: cycles since reset release, displayed/pending words, and
   // the DPMask/BlankEn values captured at the latest clock edge
   int          m_t     = 0;
   logic [31:0] m_act   = 32'h0;
   logic [31:0] m_pend  = 32'h0;
   bit          m_pfull = 1'b0;
   logic [7:0]  m_dpm   = 8'h00;
   bit          m_blk   = 1'b0;

   logic [6:0] seg_lut [16];
   initial begin
      seg_lut[0]  = 7'h40; seg_lut[1]  = 7'h79; seg_lut[2]  = 7'h24; seg_lut[3]  = 7'h30;
      seg_lut[4]  = 7'h19; seg_lut[5]  = 7'h12; seg_lut[6]  = 7'h02; seg_lut[7]  = 7'h78;
      seg_lut[8]  = 7'h00; seg_lut[9]  = 7'h10; seg_lut[10] = 7'h08; seg_lut[11] = 7'h03;
      seg_lut[12] = 7'h46; seg_lut[13] = 7'h21; seg_lut[14] = 7'h06; seg_lut[15] = 7'h0E;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d, model t %0d)", name, got, exp, cyc, m_t);
      end
   endtask

   // Model update: the handshake and promotion rules applied to pre-edge inputs
   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         m_t     = 0;
         m_act   = 32'h0;
         m_pend  = 32'h0;
         m_pfull = 1'b0;
         m_blk   = 1'b0;
      end else begin
         if (DataValid && !m_pfull) begin
            m_pend  = Data;
            m_pfull = 1'b1;
         end else if ((m_t % FRAME) == FRAME - 1 && m_pfull) begin
            m_act   = m_pend;
            m_pfull = 1'b0;
         end
         m_dpm = DPMask;
         m_blk = BlankEn;
         m_t++;
      end
   end

   // Every-cycle comparison against the frame-position model
   int          c_p, c_d, c_q;
   logic [31:0] c_up;
   always @(negedge Clock) begin
      if (cmp_en) begin
         c_p  = m_t % FRAME;
         c_d  = c_p / SLOT;
         c_q  = c_p % SLOT;
         c_up = m_act >> (4 * c_d);
         check("m_ready", DataReady, !m_pfull);
         check("m_framedone", FrameDone, c_p == FRAME - 1);
         if (c_q < GAP) begin
            check("m_gap_en", en_out, 8'hFF);
            check("m_gap_seg", out7, 7'h7F);
            check("m_gap_dp", dp, 1'b1);
         end else if (m_blk && c_d != 0 && c_up == 0) begin
            check("m_blank_en", en_out, 8'hFF);
         end else begin
            check("m_on_en", en_out, 8'hFF ^ (8'h01 << c_d));
            check("m_on_seg", out7, seg_lut[c_up[3:0]]);
            check("m_on_dp", dp, !m_dpm[c_d]);
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
      cyc++;
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   task automatic offer(input logic [31:0] w);
      Data      = w;
      DataValid = 1'b1;
      tick();
      DataValid = 1'b0;
      Data      = 32'hDEAD_BEEF;
   endtask

   initial begin
      repeat (3) @(posedge Clock);
      #1;
      Reset  = 1'b0;
      cyc    = 0;
      cmp_en = 1'b1;

      // Reset release: one GAP cycle, then digit 0 shows '0'
      @(negedge Clock); check("t1_gap_en", en_out, 8'hFF);
      check("t1_ready", DataReady, 1'b1);
      goto(1); @(negedge Clock); check("t1_on_en", en_out, 8'hFE);
      check("t1_on_seg", out7, 7'h40);

      // Load at cycle 3; promoted at the first FrameDone
      goto(3); offer(32'h1234ABCD);
      @(negedge Clock); check("t2_ready_low", DataReady, 1'b0);
      goto(39); @(negedge Clock); check("t1_framedone", FrameDone, 1'b1);
      check("t2_ready_at_fd", DataReady, 1'b0);
      goto(40); @(negedge Clock); check("t2_ready_back", DataReady, 1'b1);
      goto(41); @(negedge Clock); check("t2_d0_seg", out7, 7'h21);
      check("t2_d0_en", en_out, 8'hFE);
      goto(76); @(negedge Clock); check("t2_d7_seg", out7, 7'h79);
      check("t2_d7_en", en_out, 8'h7F);

      // Decimal points on digits 0 and 7 only, never in GAP
      goto(80); DPMask = 8'h81;
      goto(81); @(negedge Clock); check("t6_dp_d0", dp, 1'b0);
      goto(85); @(negedge Clock); check("t6_dp_gap", dp, 1'b1);
      goto(86); @(negedge Clock); check("t6_dp_d1", dp, 1'b1);

      // The second offer while pending is full must be ignored
      goto(90); offer(32'h000000F0);
      goto(95); offer(32'h55555555);
      @(negedge Clock); check("t4_ready_full", DataReady, 1'b0);
      goto(116); @(negedge Clock); check("t6_dp_d7", dp, 1'b0);
      check("t6_d7_en", en_out, 8'h7F);

      // Leading-zero blanking with active = 000000F0
      goto(120); BlankEn = 1'b1;
      goto(121); @(negedge Clock); check("t3_d0_seg", out7, 7'h40);
      check("t3_d0_en", en_out, 8'hFE);
      goto(126); @(negedge Clock); check("t3_d1_seg", out7, 7'h0E);
      check("t3_d1_en", en_out, 8'hFD);
      goto(131); @(negedge Clock); check("t3_d2_blank", en_out, 8'hFF);
      goto(156); @(negedge Clock); check("t3_d7_blank", en_out, 8'hFF);

      // Offer on the FrameDone cycle with pending empty: shown one frame later
      goto(159); @(negedge Clock); check("t4_fd", FrameDone, 1'b1);
      check("t4_ready_fd", DataReady, 1'b1);
      offer(32'h00000A00);
      @(negedge Clock); check("t4_ready_low", DataReady, 1'b0);
      goto(166); @(negedge Clock); check("t4_still_old", out7, 7'h0E);
      goto(206); @(negedge Clock); check("t4_d1_seg", out7, 7'h40);
      check("t4_d1_en", en_out, 8'hFD);
      goto(211); @(negedge Clock); check("t4_d2_seg", out7, 7'h08);
      goto(216); @(negedge Clock); check("t4_d3_blank", en_out, 8'hFF);

      // Reset mid-ON of digit 5 with pending full
      goto(240); BlankEn = 1'b0;
      goto(242); offer(32'hFFFFFFFF);
      goto(267); #1; check("t5_pre_en", en_out, 8'hDF);
      Reset = 1'b1;
      #1;
      check("t5_rst_en", en_out, 8'hFF);
      check("t5_rst_seg", out7, 7'h7F);
      check("t5_rst_dp", dp, 1'b1);
      check("t5_rst_fd", FrameDone, 1'b0);
      check("t5_rst_ready", DataReady, 1'b1);
      tick(); tick();
      Reset = 1'b0;
      cyc   = 0;
      goto(1); @(negedge Clock); check("t5_post_seg", out7, 7'h40);
      goto(39); @(negedge Clock); check("t5_fd", FrameDone, 1'b1);
      goto(41); @(negedge Clock); check("t5_discarded", out7, 7'h40);
      goto(45);

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
